hilo_seq_unit: RTL and testbench

HILO_SEQ_UNIT -- requirements
Module: hilo_seq_unit

---
 rtl/hilo_seq_unit_pkg.sv | 24 ++
 rtl/hilo_seq_unit.sv | 127 ++++++++++++
 tb/tb_hilo_seq_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_seq_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// iteration count, FSM state type and an operand magnitude helper.
package hilo_seq_unit_pkg;

  localparam logic [1:0] MD_DIV   = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_MULTU = 2'b11;

  localparam int unsigned MD_ITER   = 32;
  localparam logic [5:0]  ITER_LAST = 6'(MD_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mdState_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] magOf(input logic [31:0] x, input logic isSigned);
    return (isSigned && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/hilo_seq_unit.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO
// registers, with mthi/mtlo write ports and sign fix-up on completion.
module hilo_seq_unit
  import hilo_seq_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mdOp,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        hiWe,
  input  logic        loWe,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdState_t    state, nextState;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        isMul;
  logic        resSign;
  logic        dvdSign;

  logic        opSigned;
  logic [32:0] addA, addB, sum;
  logic        divGe;
  logic [63:0] accNext;
  logic [63:0] prodFix;
  logic [31:0] quoFix, remFix;
  logic [31:0] resHi, resLo;

  assign opSigned = ~mdOp[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) nextState = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == ITER_LAST) nextState = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // One 33-bit adder serves both: add for shift-add multiply, subtract for
  // the restoring-division trial (remainder shifted left with next dividend bit).
  always_comb begin
    addA    = isMul ? {1'b0, acc[63:32]} : acc[63:31];
    addB    = {1'b0, opnd};
    sum     = addA + (addB ^ {33{~isMul}}) + {32'd0, ~isMul};
    divGe   = acc[63] | ~sum[32];
    accNext = acc;
    if (isMul) begin
      accNext = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    end else begin
      accNext = divGe ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    end
  end

  always_comb begin
    prodFix = resSign ? (~acc + 64'd1) : acc;
    quoFix  = resSign ? (~acc[31:0] + 32'd1) : acc[31:0];
    remFix  = dvdSign ? (~acc[63:32] + 32'd1) : acc[63:32];
    resHi   = isMul ? prodFix[63:32] : remFix;
    resLo   = isMul ? prodFix[31:0]  : quoFix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      isMul   <= 1'b0;
      resSign <= 1'b0;
      dvdSign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          isMul   <= mdOp[1];
          acc     <= {32'd0, magOf(din1, opSigned)};
          opnd    <= magOf(din2, opSigned);
          resSign <= opSigned & (din1[31] ^ din2[31]);
          dvdSign <= opSigned & din1[31];
        end
        CALC: begin
          acc <= accNext;
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // The completing operation takes priority over a coincident mthi/mtlo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      hi <= resHi;
      lo <= resLo;
    end else begin
      if (hiWe) hi <= wdata;
      if (loWe) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_hilo_seq_unit.sv
// Directed self-checking bench for hilo_seq_unit.
module tb_hilo_seq_unit;
  import hilo_seq_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mdOp;
  logic [31:0] din1, din2;
  logic        hiWe, loWe;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int cmpCount = 0;
  int errCount = 0;

  hilo_seq_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mdOp  (mdOp),
    .din1  (din1),
    .din2  (din2),
    .hiWe  (hiWe),
    .loWe  (loWe),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; mdOp = MD_DIV; din1 = '0; din2 = '0;
    hiWe = 1'b0; loWe = 1'b0; wdata = '0;
    #1 rst_n = 1'b0;
    #2;
    cmpCount++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errCount++;
      $display("FAIL reset_ctrl: busy=%b done=%b expected busy=0 done=0", busy, done);
    end
    cmpCount++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errCount++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  // Issues one operation at cycle 0 and checks the busy/done profile for
  // cycles 1..33 and the result in cycle 34. injCyc re-asserts start (mult 2x2)
  // while busy; loCyc pulses loWe with 0xDEAD.
  task automatic doOp(input string name, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expHi, input logic [31:0] expLo,
                      input int injCyc, input int loCyc);
    int badProf;
    badProf = 0;
    mdOp = op; din1 = a; din2 = b; start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== logic'(c == 33)) badProf++;
      if (c == injCyc) begin
        start = 1'b1; mdOp = MD_MULT; din1 = 32'd2; din2 = 32'd2;
      end
      if (c == loCyc) begin
        loWe = 1'b1; wdata = 32'hDEAD;
      end
      stepCycle();
      start = 1'b0;
      loWe  = 1'b0;
    end
    cmpCount++;
    if (badProf != 0) begin
      errCount++;
      $display("FAIL %s_timing: %0d cycles with wrong busy/done, expected 0", name, badProf);
    end
    cmpCount++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errCount++;
      $display("FAIL %s_idle: busy=%b done=%b expected 0/0", name, busy, done);
    end
    cmpCount++;
    if (hi !== expHi || lo !== expLo) begin
      errCount++;
      $display("FAIL %s_result: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, expHi, expLo);
    end
  endtask

  task automatic test_mult();
    doOp("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
    doOp("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
  endtask

  task automatic test_div();
    doOp("div_neg",      MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    doOp("div_ovf",      MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0);
    doOp("divu_zero",    MD_DIVU, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0, 0);
    doOp("div_zero_neg", MD_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001, 0, 0);
    doOp("div_zero_pos", MD_DIV,  32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF, 0, 0);
  endtask

  task automatic test_busy_ignore();
    doOp("divu_inj", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5, 0);
  endtask

  task automatic test_writes();
    hiWe = 1'b1; wdata = 32'h1234;
    stepCycle();
    hiWe = 1'b0;
    cmpCount++;
    if (hi !== 32'h1234 || lo !== 32'd14) begin
      errCount++;
      $display("FAIL mthi_idle: hi=%h lo=%h expected hi=00001234 lo=0000000e", hi, lo);
    end
    doOp("multu_lowe", MD_MULTU, 32'd3, 32'd4, 32'h0, 32'h0000000C, 0, 33);
  endtask

  task automatic test_start_with_write();
    mdOp = MD_DIVU; din1 = 32'd100; din2 = 32'd7; start = 1'b1;
    hiWe = 1'b1; wdata = 32'hAAAA5555;
    stepCycle();
    start = 1'b0; hiWe = 1'b0;
    cmpCount++;
    if (hi !== 32'hAAAA5555 || busy !== 1'b1) begin
      errCount++;
      $display("FAIL start_mthi: hi=%h busy=%b expected hi=aaaa5555 busy=1", hi, busy);
    end
    for (int c = 1; c <= 33; c++) stepCycle();
    cmpCount++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errCount++;
      $display("FAIL start_mthi_result: hi=%h lo=%h expected hi=00000002 lo=0000000e", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    int doneSeen;
    doneSeen = 0;
    mdOp = MD_DIVU; din1 = 32'd100; din2 = 32'd7; start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) begin
        start = 1'b1; mdOp = MD_MULT; din1 = 32'd2; din2 = 32'd2;
      end
      stepCycle();
      start = 1'b0;
    end
    cmpCount++;
    if (busy !== 1'b1) begin
      errCount++;
      $display("FAIL abort_prebusy: busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    cmpCount++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errCount++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    stepCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
      stepCycle();
    end
    cmpCount++;
    if (doneSeen != 0 || hi !== 32'h0 || lo !== 32'h0) begin
      errCount++;
      $display("FAIL abort_quiet: %0d active cycles hi=%h lo=%h expected 0 active, hi=lo=0",
               doneSeen, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_writes();
    test_start_with_write();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
